eq_band_mixer: RTL and testbench

- Recombination stage of the equalizer; the inverse of the 10-way FIR band split.
- Takes the ten band outputs (lowpass, 8 octave bands, highpass) for one audio sample.
- Scales each band by a programmable signed gain and sums the results into one 24-bit output sample.
- Uses a single time-multiplexed multiply-accumulate (one band per clock), then rounds and saturates.

---
 rtl/eq_band_mixer.sv | 134 +++++++++++++
 tb/tb_eq_band_mixer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer.sv
// Equalizer recombination: scales ten band samples by programmable Q2.14 gains and sums them
// on a single time-multiplexed MAC. Optional per-band mute enabled by defining EQ_BAND_MUTE_EN.
module eq_band_mixer #(
  parameter int            NBANDS = 10,
  parameter int            GW     = 16,
  parameter logic [GW-1:0] UNITY  = 16'h4000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [23:0] i_band_lp,
  input  logic [23:0] i_band_64_125,
  input  logic [23:0] i_band_125_250,
  input  logic [23:0] i_band_250_500,
  input  logic [23:0] i_band_500_1k,
  input  logic [23:0] i_band_1k_2k,
  input  logic [23:0] i_band_2k_4k,
  input  logic [23:0] i_band_4k_8k,
  input  logic [23:0] i_band_8k_16k,
  input  logic [23:0] i_band_hp,
  input  logic        i_gain_wr,
  input  logic [3:0]  i_gain_addr,
  input  logic [15:0] i_gain_data,
`ifdef EQ_BAND_MUTE_EN
  input  logic [9:0]  i_mute,
`endif
  output logic        o_gain_rdy,
  output logic [23:0] o_data,
  output logic        o_valid,
  output logic        o_overrun
);

  localparam int DATA_W = 24;
  localparam int PROD_W = DATA_W + GW;
  localparam int ACC_W  = PROD_W + 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(8192);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(8388607);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + RND) >>> (GW - 2);
    if (r > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (r < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return r[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] band_in [NBANDS];
  logic [NBANDS-1:0]        mute_in;
  logic signed [GW-1:0]     gain    [NBANDS];

  logic signed [DATA_W-1:0] band_p0 [NBANDS];
  logic signed [GW-1:0]     gain_p0 [NBANDS];
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic [1:0]               state;
  logic [3:0]               idx;

  assign band_in[0] = i_band_lp;
  assign band_in[1] = i_band_64_125;
  assign band_in[2] = i_band_125_250;
  assign band_in[3] = i_band_250_500;
  assign band_in[4] = i_band_500_1k;
  assign band_in[5] = i_band_1k_2k;
  assign band_in[6] = i_band_2k_4k;
  assign band_in[7] = i_band_4k_8k;
  assign band_in[8] = i_band_8k_16k;
  assign band_in[9] = i_band_hp;

`ifdef EQ_BAND_MUTE_EN
  assign mute_in = i_mute;
`else
  assign mute_in = '0;
`endif

  assign o_gain_rdy = (state == S_IDLE);

  // Stage p0: sample buffer; gains are snapshotted with the bands so a write landing on the
  // same edge only affects the following sample.
  always_ff @(posedge i_clk) begin
    if (state == S_IDLE && i_en) begin
      for (int i = 0; i < NBANDS; i++) begin
        band_p0[i] <= mute_in[i] ? '0 : band_in[i];
        gain_p0[i] <= gain[i];
      end
    end
  end

  assign prod_p0 = band_p0[idx] * gain_p0[idx];

  // Stage p1: accumulate one band per clock, then round/saturate into the output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc_p1    <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      for (int i = 0; i < NBANDS; i++) gain[i] <= UNITY;
    end else begin
      o_valid <= 1'b0;
      if (i_en && state != S_IDLE) o_overrun <= 1'b1;
      if (state == S_IDLE && i_gain_wr && i_gain_addr < 4'(NBANDS))
        gain[i_gain_addr] <= i_gain_data;
      case (state)
        S_IDLE: begin
          if (i_en) begin
            acc_p1 <= '0;
            idx    <= '0;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          acc_p1 <= acc_p1 + ACC_W'(prod_p0);
          if (idx == 4'(NBANDS - 1)) state <= S_OUT;
          else                       idx   <= idx + 4'd1;
        end
        S_OUT: begin
          o_data  <= round_sat(acc_p1);
          o_valid <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Randomized self-checking bench for eq_band_mixer against a plain-arithmetic mix model.
// Define EQ_BAND_MUTE_EN for both files to exercise the mute port.
module tb_eq_band_mixer;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_gain_wr = 1'b0;
  logic [3:0]  i_gain_addr = '0;
  logic [15:0] i_gain_data = '0;
  logic        o_gain_rdy;
  logic [23:0] o_data;
  logic        o_valid;
  logic        o_overrun;

  logic signed [23:0] band_v [10];
  logic [9:0]         mute_v = '0;
  logic signed [15:0] gm     [10];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eq_band_mixer dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_en           (i_en),
    .i_band_lp      (band_v[0]),
    .i_band_64_125  (band_v[1]),
    .i_band_125_250 (band_v[2]),
    .i_band_250_500 (band_v[3]),
    .i_band_500_1k  (band_v[4]),
    .i_band_1k_2k   (band_v[5]),
    .i_band_2k_4k   (band_v[6]),
    .i_band_4k_8k   (band_v[7]),
    .i_band_8k_16k  (band_v[8]),
    .i_band_hp      (band_v[9]),
    .i_gain_wr      (i_gain_wr),
    .i_gain_addr    (i_gain_addr),
    .i_gain_data    (i_gain_data),
`ifdef EQ_BAND_MUTE_EN
    .i_mute         (mute_v),
`endif
    .o_gain_rdy     (o_gain_rdy),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_overrun      (o_overrun)
  );

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Mixed sample = clamp(floor((sum band*gain + 2^13) / 2^14)).
  function automatic longint model();
    longint s = 0;
    for (int i = 0; i < 10; i++)
`ifdef EQ_BAND_MUTE_EN
      if (!mute_v[i])
`endif
        s += longint'(band_v[i]) * longint'(gm[i]);
    s = (s + 8192) >>> 14;
    if (s > 8388607)  s = 8388607;
    if (s < -8388608) s = -8388608;
    return s;
  endfunction

  task automatic set_bands(input int v);
    for (int i = 0; i < 10; i++) band_v[i] = 24'(v);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    for (int i = 0; i < 10; i++) gm[i] = 16'sh4000;
  endtask

  task automatic wr_gain(input logic [3:0] a, input logic [15:0] d);
    int guard = 0;
    while (!o_gain_rdy && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    check("wr_gain_rdy", o_gain_rdy, 1);
    i_gain_wr = 1'b1; i_gain_addr = a; i_gain_data = d;
    @(posedge clk); #1;
    i_gain_wr = 1'b0;
    if (a < 10) gm[a] = d;
  endtask

  // Pulse i_en (optionally with a same-edge gain write) and check latency, data and pulse width.
  task automatic mix(input string tag, input logic do_wr, input logic [3:0] wa, input logic [15:0] wd,
                     output longint got);
    longint exp;
    int lat = 0;
    exp = model();
    i_en = 1'b1;
    i_gain_wr = do_wr; i_gain_addr = wa; i_gain_data = wd;
    @(posedge clk); #1;
    i_en = 1'b0; i_gain_wr = 1'b0;
    if (do_wr && wa < 10) gm[wa] = wd;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (o_valid) lat = k;
    end
    check({tag, "_lat"}, lat, 11);
    got = longint'($signed(o_data));
    check({tag, "_data"}, got, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, o_valid, 0);
    check({tag, "_hold"}, longint'($signed(o_data)), got);
  endtask

  initial begin
    longint got;
    int nv, k_acc;
    logic acc_now;
    set_bands(0);
    for (int i = 0; i < 10; i++) gm[i] = 16'sh4000;
    do_reset();

    check("rst_data", o_data, 0);
    check("rst_valid", o_valid, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_rdy", o_gain_rdy, 1);

    set_bands(1000);
    mix("unity", 1'b0, 4'd0, 16'h0, got);
    check("unity_const", got, 10000);
    check("unity_ovr", o_overrun, 0);

    wr_gain(4'd0, 16'h2000);
    set_bands(0); band_v[0] = 24'sd1;
    mix("half_pos", 1'b0, 4'd0, 16'h0, got);
    check("half_pos_const", got, 1);
    band_v[0] = -24'sd1;
    mix("half_neg", 1'b0, 4'd0, 16'h0, got);
    check("half_neg_const", got, 0);

    for (int i = 0; i < 10; i++) wr_gain(4'(i), 16'h7FFF);
    set_bands(24'h7FFFFF);
    mix("sat_pos", 1'b0, 4'd0, 16'h0, got);
    check("sat_pos_const", got, 8388607);
    set_bands(24'h800000);
    mix("sat_neg", 1'b0, 4'd0, 16'h0, got);
    check("sat_neg_const", got, -8388608);

    for (int i = 0; i < 10; i++) wr_gain(4'(i), 16'h4000);
    wr_gain(4'd3, 16'h0000);
    wr_gain(4'd12, 16'h0000);
    set_bands(0); band_v[0] = 24'sd5000; band_v[3] = 24'sd5000;
    mix("gain_zero", 1'b0, 4'd0, 16'h0, got);
    check("gain_zero_const", got, 5000);

    // Overrun: second i_en at T+5, plus a gain write held from the MAC phase until ready.
    set_bands(300);
    nv = 0; k_acc = 0;
    i_en = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 25; k++) begin
      i_en = (k == 5);
      if (k == 2) begin
        check("busy_rdy", o_gain_rdy, 0);
        i_gain_wr = 1'b1; i_gain_addr = 4'd1; i_gain_data = 16'h0000;
      end
      acc_now = i_gain_wr && o_gain_rdy;
      @(posedge clk); #1;
      if (acc_now) begin
        i_gain_wr = 1'b0; gm[1] = 16'sh0000; k_acc = k;
      end
      if (o_valid) nv++;
    end
    i_en = 1'b0; i_gain_wr = 1'b0;
    check("ovr_nvalid", nv, 1);
    check("ovr_flag", o_overrun, 1);
    check("wr_hold_edge", k_acc, 12);
    set_bands(0); band_v[1] = 24'sd4000; band_v[2] = 24'sd700;
    mix("held_wr", 1'b0, 4'd0, 16'h0, got);
    check("held_wr_const", got, 700);
    check("ovr_sticky", o_overrun, 1);

    // Same-edge write and i_en: the current sample still uses the old gain.
    do_reset();
    check("rst2_ovr", o_overrun, 0);
    set_bands(1000);
    mix("simul", 1'b1, 4'd0, 16'h0000, got);
    check("simul_const", got, 10000);
    mix("simul_next", 1'b0, 4'd0, 16'h0, got);
    check("simul_next_const", got, 9000);

    // Reset while the MAC is at idx 5.
    i_en = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b0; nv = 0;
    for (int k = 1; k <= 20; k++) begin
      i_rst = (k == 6);
      @(posedge clk); #1;
      if (o_valid) nv++;
    end
    i_rst = 1'b0;
    for (int i = 0; i < 10; i++) gm[i] = 16'sh4000;
    check("midrst_nvalid", nv, 0);
    check("midrst_data", o_data, 0);
    check("midrst_ovr", o_overrun, 0);
    check("midrst_rdy", o_gain_rdy, 1);
    set_bands(1234);
    mix("post_rst", 1'b0, 4'd0, 16'h0, got);
    check("post_rst_const", got, 12340);

`ifdef EQ_BAND_MUTE_EN
    set_bands(0); band_v[0] = 24'sd7; mute_v = 10'h001;
    mix("mute", 1'b0, 4'd0, 16'h0, got);
    check("mute_const", got, 0);
    mute_v = '0;
`endif

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        wr_gain(4'($urandom_range(0, 15)), 16'($urandom));
      for (int i = 0; i < 10; i++)
        band_v[i] = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($signed(17'($urandom)));
`ifdef EQ_BAND_MUTE_EN
      mute_v = 10'($urandom);
`endif
      mix("rand", $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 16'($urandom), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
